// File: rtl/key_voice_pkg.sv
// Shared types and helpers for the key-to-voice allocator.
// Defaults here match the default build of key_voice_allocator.
package key_voice_pkg;

    localparam int MAX_VOICES      = 8;
    localparam int DEF_NUM_KEYS    = 32;
    localparam int DEF_RELEASE_CYC = 1024;
    localparam int KW              = $clog2(DEF_NUM_KEYS);
    localparam int RC_W            = $clog2(DEF_RELEASE_CYC + 1);

    typedef enum logic [1:0] {
        FREE    = 2'd0,
        ACTIVE  = 2'd1,
        RELEASE = 2'd2
    } voice_state_e;

    typedef struct packed {
        logic       found;
        logic [2:0] idx;
    } lowest_t;

    function automatic lowest_t lowest_set(input logic [MAX_VOICES-1:0] vec);
        lowest_t res;
        res = '0;
        for (int i = MAX_VOICES - 1; i >= 0; i--) begin
            if (vec[i]) begin
                res.found = 1'b1;
                res.idx   = 3'(i);
            end
        end
        return res;
    endfunction

    function automatic logic [MAX_VOICES-1:0] to_onehot(input lowest_t sel);
        return sel.found ? (MAX_VOICES'(1) << sel.idx) : '0;
    endfunction

endpackage

// File: rtl/key_voice_allocator_slot.sv
// One voice slot: state, held key, release tail counter and optional recency rank.
// The rank exists only when KEY_VOICE_ALLOCATOR_STEAL_EN is defined.
module voice_slot
    import key_voice_pkg::*;
#(
`ifdef KEY_VOICE_ALLOCATOR_STEAL_EN
    parameter int RANK_W      = 2,
    parameter int RANK_INIT   = 0,
`endif
    parameter int KEY_W       = KW,
    parameter int CNT_W       = RC_W,
    parameter int RELEASE_CYC = DEF_RELEASE_CYC
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_alloc,
    input  logic               i_release,
    input  logic [KEY_W-1:0]   i_key,
`ifdef KEY_VOICE_ALLOCATOR_STEAL_EN
    input  logic               i_alloc_any,
    input  logic [RANK_W-1:0]  i_alloc_rank,
    output logic [RANK_W-1:0]  o_rank,
`endif
    output voice_state_e       o_state,
    output logic               o_gate,
    output logic               o_active,
    output logic               o_note_on,
    output logic [KEY_W-1:0]   o_key
);

    voice_state_e       r_state;
    logic [KEY_W-1:0]   r_key;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_note_on;

    // NOTE: state registers use non-blocking assignments so every slot samples
    // the same pre-edge values, regardless of evaluation order.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state   <= FREE;
            r_key     <= '0;
            r_cnt     <= '0;
            r_note_on <= 1'b0;
        end else begin
            r_note_on <= i_alloc;
            // Allocation outranks an expiring tail, so a retrigger never loses the voice.
            if (i_alloc) begin
                r_state <= ACTIVE;
                r_key   <= i_key;
                r_cnt   <= '0;
            end else if (i_release) begin
                r_state <= RELEASE;
                r_cnt   <= CNT_W'(RELEASE_CYC - 1);
            end else if (r_state == RELEASE) begin
                if (r_cnt == '0) r_state <= FREE;
                else             r_cnt   <= r_cnt - 1'b1;
            end
        end
    end

`ifdef KEY_VOICE_ALLOCATOR_STEAL_EN
    logic [RANK_W-1:0] r_rank;

    // Ranks start as a permutation so exactly one voice is always the oldest.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)                                        r_rank <= RANK_W'(RANK_INIT);
        else if (i_alloc)                                    r_rank <= '0;
        else if (i_alloc_any && (r_rank < i_alloc_rank))     r_rank <= r_rank + 1'b1;
    end

    assign o_rank = r_rank;
`endif

    assign o_state   = r_state;
    assign o_gate    = (r_state == ACTIVE);
    assign o_active  = (r_state != FREE);
    assign o_note_on = r_note_on;
    assign o_key     = r_key;

endmodule

// File: rtl/key_voice_allocator.sv
// Polyphonic voice scheduler: scans the key-held vector, allocates/releases voices.
// Define KEY_VOICE_ALLOCATOR_STEAL_EN to steal the oldest voice instead of dropping presses.
module key_voice_allocator
    import key_voice_pkg::*;
#(
    parameter int NUM_VOICES  = 4,
    parameter int NUM_KEYS    = DEF_NUM_KEYS,
    parameter int RELEASE_CYC = DEF_RELEASE_CYC
) (
    input  logic                                  i_clk,
    input  logic                                  i_rst_n,
    input  logic [NUM_KEYS-1:0]                   i_key,
    output logic [NUM_VOICES*$clog2(NUM_KEYS)-1:0] o_voice_key,
    output logic [NUM_VOICES-1:0]                 o_voice_gate,
    output logic [NUM_VOICES-1:0]                 o_voice_active,
    output logic [NUM_VOICES-1:0]                 o_note_on,
    output logic [7:0]                            o_drop_cnt
);

    localparam int KEY_W = $clog2(NUM_KEYS);
    localparam int CNT_W = $clog2(RELEASE_CYC + 1);

    logic [NUM_KEYS-1:0]   r_seen;
    logic [KEY_W-1:0]      r_ptr;
    logic [7:0]            r_drop_cnt;

    voice_state_e          w_state [NUM_VOICES];
    logic [KEY_W-1:0]      w_key   [NUM_VOICES];
    logic [NUM_VOICES-1:0] w_free_vec, w_rel_vec, w_hold_vec;
    logic [NUM_VOICES-1:0] w_alloc, w_release;
    lowest_t               w_lf, w_lr, w_lh;
    logic                  w_press, w_unpress, w_drop;

`ifdef KEY_VOICE_ALLOCATOR_STEAL_EN
    localparam int RANK_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
    logic [RANK_W-1:0]     w_rank [NUM_VOICES];
    logic [RANK_W-1:0]     w_alloc_rank;
    logic [NUM_VOICES-1:0] w_steal_vec;
`endif

    // NOTE: every combinational output gets a default first so no path can infer a latch.
    always_comb begin
        w_free_vec = '0;
        w_rel_vec  = '0;
        w_hold_vec = '0;
        for (int v = 0; v < NUM_VOICES; v++) begin
            w_free_vec[v] = (w_state[v] == FREE);
            w_rel_vec[v]  = (w_state[v] == RELEASE);
            w_hold_vec[v] = (w_state[v] == ACTIVE) && (w_key[v] == r_ptr);
        end
        w_lf      = lowest_set(MAX_VOICES'(w_free_vec));
        w_lr      = lowest_set(MAX_VOICES'(w_rel_vec));
        w_lh      = lowest_set(MAX_VOICES'(w_hold_vec));
        w_press   =  i_key[r_ptr] & ~r_seen[r_ptr];
        w_unpress = ~i_key[r_ptr] &  r_seen[r_ptr];
        w_alloc   = '0;
        w_release = '0;
        w_drop    = 1'b0;
        if (w_press) begin
            if (w_lf.found)      w_alloc = NUM_VOICES'(to_onehot(w_lf));
            else if (w_lr.found) w_alloc = NUM_VOICES'(to_onehot(w_lr));
            else begin
`ifdef KEY_VOICE_ALLOCATOR_STEAL_EN
                w_alloc = w_steal_vec;
`else
                w_drop  = 1'b1;
`endif
            end
        end
        if (w_unpress) w_release = NUM_VOICES'(to_onehot(w_lh));
    end

`ifdef KEY_VOICE_ALLOCATOR_STEAL_EN
    always_comb begin
        w_steal_vec  = '0;
        w_alloc_rank = '0;
        for (int v = 0; v < NUM_VOICES; v++) begin
            w_steal_vec[v] = (w_rank[v] == RANK_W'(NUM_VOICES - 1));
            if (w_alloc[v]) w_alloc_rank = w_alloc_rank | w_rank[v];
        end
    end
`endif

    // NOTE: only control state is reset here; no memories exist that would need clearing.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_seen     <= '0;
            r_ptr      <= '0;
            r_drop_cnt <= '0;
        end else begin
            r_ptr <= (r_ptr == KEY_W'(NUM_KEYS - 1)) ? '0 : r_ptr + 1'b1;
            // A dropped press is still marked seen so it is not retried every scan.
            if (w_press || w_unpress) r_seen[r_ptr] <= w_press;
            if (w_drop && (r_drop_cnt != 8'hFF)) r_drop_cnt <= r_drop_cnt + 8'd1;
        end
    end

    for (genvar v = 0; v < NUM_VOICES; v++) begin : g_voice
        voice_slot #(
`ifdef KEY_VOICE_ALLOCATOR_STEAL_EN
            .RANK_W      (RANK_W),
            .RANK_INIT   (v),
`endif
            .KEY_W       (KEY_W),
            .CNT_W       (CNT_W),
            .RELEASE_CYC (RELEASE_CYC)
        ) u_slot (
            .i_clk        (i_clk),
            .i_rst_n      (i_rst_n),
            .i_alloc      (w_alloc[v]),
            .i_release    (w_release[v]),
            .i_key        (r_ptr),
`ifdef KEY_VOICE_ALLOCATOR_STEAL_EN
            .i_alloc_any  (|w_alloc),
            .i_alloc_rank (w_alloc_rank),
            .o_rank       (w_rank[v]),
`endif
            .o_state      (w_state[v]),
            .o_gate       (o_voice_gate[v]),
            .o_active     (o_voice_active[v]),
            .o_note_on    (o_note_on[v]),
            .o_key        (w_key[v])
        );
        assign o_voice_key[v*KEY_W +: KEY_W] = w_key[v];
    end

    assign o_drop_cnt = r_drop_cnt;

endmodule
